fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: next-PC select, instruction memory handshake and IF/ID payload register.
// Optional FETCH_DELAY_SLOT_EN keeps the instruction fetched alongside a redirect as a delay slot.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc,
  output logic [31:0] npc,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] inst,
  output logic [31:0] pc4,
  output logic        inst_valid,
  output logic [31:0] fetch_cnt,
  output logic [15:0] wait_cnt
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] WAIT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  logic            run;
  logic            xfer;
  logic            redirect;
  logic            keep;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] target;

  // Request, next-PC and transfer qualification; clr forces the idle view immediately.
  always_comb begin
    run       = (state == RUN) && !clr;
    pc_inc    = pc + XLEN'(4);
    imem_addr = pc;
    imem_req  = run && !(inst_valid && stall);
    xfer      = imem_req && imem_ack;
    redirect  = (pcsource != 2'b00);
    target    = pc_inc;
    unique case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = rpc;
      2'b11:   target = jpc;
      default: target = pc_inc;
    endcase
`ifdef FETCH_DELAY_SLOT_EN
    keep = xfer;
`else
    keep = xfer && !redirect;
`endif
    if (!run) begin
      npc = RESET_VECTOR;
    end else if (redirect) begin
      npc = target;
    end else if (xfer) begin
      npc = pc_inc;
    end else begin
      npc = pc;
    end
  end

  // State, IF/ID payload and performance counters.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      inst       <= '0;
      pc4        <= '0;
      inst_valid <= 1'b0;
      fetch_cnt  <= '0;
      wait_cnt   <= '0;
    end else begin
      state <= RUN;
      if (run) begin
        if (keep) begin
          inst       <= imem_data;
          pc4        <= pc_inc;
          inst_valid <= 1'b1;
          fetch_cnt  <= fetch_cnt + XLEN'(1);
        end else if (!stall) begin
          inst_valid <= 1'b0;
        end
        // Saturating count of cycles the memory left a request waiting
        if (imem_req && !imem_ack && (wait_cnt != WAIT_MAX)) begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a per-cycle reference model plus a payload scoreboard
// drained by an independent monitor whenever the fetch counter advances.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] pc = 32'h0;
  logic [31:0] npc;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = 32'h0, rpc = 32'h0, jpc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] inst, pc4, fetch_cnt;
  logic        inst_valid;
  logic [15:0] wait_cnt;

  fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .clr(clr), .pc(pc), .npc(npc), .pcsource(pcsource),
    .bpc(bpc), .rpc(rpc), .jpc(jpc), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst(inst), .pc4(pc4), .inst_valid(inst_valid), .fetch_cnt(fetch_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  // The PC register the fetch unit expects to sit beside it
  always @(posedge clk) pc <= npc;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state (what the registered outputs should hold now)
  bit          m_run = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_inst = 32'h0, m_pc4 = 32'h0, m_fetch = 32'h0;
  int          m_wait = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = 32'h0000_0100;
      1:       r = 32'hFFFF_FFFC;
      2:       r = 32'hFFFF_FFF8;
      default: r = $urandom & 32'hFFFF_FFFC;
    endcase
    return r;
  endfunction

  // One clock: drive inputs, compare against the model, then advance the model past the edge.
  task automatic cycle(input bit c, input bit a, input bit s, input logic [1:0] ps,
                       input logic [31:0] b, input logic [31:0] r, input logic [31:0] j,
                       input logic [31:0] d);
    logic [31:0] tgt [4];
    logic [31:0] exp_npc;
    bit          req, xf, redir, keep;
    exp_t        e;
    @(posedge clk);
    #1;
    clr = c; imem_ack = a; stall = s; pcsource = ps;
    bpc = b; rpc = r; jpc = j; imem_data = d;
    #3;
    tgt[0] = pc + 32'd4; tgt[1] = b; tgt[2] = r; tgt[3] = j;
    redir = (ps != 2'b00);
    req = 1'b0; xf = 1'b0; exp_npc = RV;
    if (!c && m_run) begin
      req = !(m_valid && s);
      xf  = req && a;
      exp_npc = (redir || xf) ? tgt[ps] : pc;
      chk("imem_addr", imem_addr, pc);
    end
    chk("imem_req", 32'(imem_req), 32'(req));
    chk("npc", npc, exp_npc);
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("fetch_cnt", fetch_cnt, m_fetch);
    chk("wait_cnt", 32'(wait_cnt), 32'(m_wait));
    if (m_valid) begin
      chk("inst", inst, m_inst);
      chk("pc4", pc4, m_pc4);
    end
    if (c) begin
      m_run = 1'b0; m_valid = 1'b0; m_inst = 32'h0; m_pc4 = 32'h0; m_fetch = 32'h0; m_wait = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else begin
      keep = xf && (DS || !redir);
      if (keep) begin
        m_inst = d; m_pc4 = pc + 32'd4; m_valid = 1'b1; m_fetch = m_fetch + 32'd1;
        e.inst = m_inst; e.pc4 = m_pc4; e.cnt = m_fetch;
        sb.push_back(e);
      end else if (!s) begin
        m_valid = 1'b0;
      end
      if (req && !a) m_wait = (m_wait < 65535) ? m_wait + 1 : 65535;
    end
  endtask

  task automatic rand_cycle(input bit allow_clr);
    bit          c;
    logic [1:0]  ps;
    c  = allow_clr && ($urandom_range(0, 199) == 0);
    ps = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    cycle(c, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, ps,
          rand_tgt(), rand_tgt(), rand_tgt(), $urandom);
  endtask

  // Monitor: each advance of the fetch counter presents one new payload
  logic [31:0] mon_last = 32'h0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (fetch_cnt !== mon_last) begin
        mon_last = fetch_cnt;
        if (fetch_cnt != 32'h0) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL sb_unexpected: fetch_cnt %h with no expected payload", fetch_cnt);
          end else begin
            e = sb.pop_front();
            chk("sb_inst", inst, e.inst);
            chk("sb_pc4", pc4, e.pc4);
            chk("sb_cnt", fetch_cnt, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    // Reset with a live ack that must be discarded
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, $urandom);
    // Always-acking memory from the reset vector
    repeat (20) cycle(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, $urandom);
    // Branch to the wrap boundary, then let pc+4 wrap to zero
    cycle(1'b0, 1'b1, 1'b0, 2'b11, 32'h0, 32'h0, 32'hFFFF_FFFC, $urandom);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, $urandom);
    // Redirect coinciding with a transfer
    cycle(1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0100, 32'h0, 32'h0, $urandom);
    repeat (3000) rand_cycle(1'b1);
    // Reset in the middle of a pending, acknowledged request
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, $urandom);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, $urandom);
    // Long memory wait to push the wait counter into saturation
    repeat (70010) cycle(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, $urandom);
    chk("wait_sat", 32'(wait_cnt), 32'h0000_FFFF);
    repeat (200) rand_cycle(1'b0);
    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
